// File: rtl/riscv_pkg.sv
// Shared types for the data-memory path: access sizes and the request bundle
// that the arbiter forwards to the memory side.
package riscv_pkg;

    localparam int unsigned DATA_W = 32;

    typedef enum logic [1:0] {
        MEM_B = 2'd0,
        MEM_H = 2'd1,
        MEM_W = 2'd2
    } mem_size_e;

    // size is kept as raw bits so the illegal encoding 2'd3 stays representable
    typedef struct packed {
        logic              req;
        logic              we;
        logic [1:0]        size;
        logic [DATA_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } mem_req_t;

endpackage

// File: rtl/dmem_lane_align.sv
// Byte-lane helper: alignment check, byte-enable generation and write-data
// shift for one data-memory request.
module dmem_lane_align
    import riscv_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [1:0]      size_i,
    input  logic [1:0]      off_i,
    input  logic [XLEN-1:0] wdata_i,
    output logic            err_o,
    output logic [3:0]      be_o,
    output logic [XLEN-1:0] wdata_o
);

    // size/offset decode into lane enables and the misalignment flag
    always_comb begin
        err_o = 1'b0;
        be_o  = 4'b0000;
        case (size_i)
            MEM_B: begin
                be_o  = 4'b0001 << off_i;
                err_o = 1'b0;
            end
            MEM_H: begin
                be_o  = 4'b0011 << off_i;
                err_o = off_i[0];
            end
            MEM_W: begin
                be_o  = 4'b1111;
                err_o = (off_i != 2'b00);
            end
            default: begin
                be_o  = 4'b0000;
                err_o = 1'b1;
            end
        endcase
    end

    assign wdata_o = wdata_i << {off_i, 3'b000};

endmodule

// File: rtl/dmem_arbiter.sv
// Shares the single-ported data memory between the CPU MEM stage and the
// debug/loader port; CPU wins ties until its grant streak hits the limit.
module dmem_arbiter
    import riscv_pkg::*;
#(
    parameter int XLEN         = 32,
    parameter int MemDepth     = 4096,
    parameter int MaxCpuStreak = 4,
    localparam int AW          = $clog2(MemDepth)
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            cpu_req_i,
    input  logic            cpu_we_i,
    input  logic [1:0]      cpu_size_i,
    input  logic [XLEN-1:0] cpu_addr_i,
    input  logic [XLEN-1:0] cpu_wdata_i,
    output logic            cpu_gnt_o,
    output logic            cpu_rvalid_o,
    output logic [XLEN-1:0] cpu_rdata_o,
    output logic            cpu_err_o,
    output logic            cpu_stall_o,
    input  logic            dbg_req_i,
    input  logic            dbg_we_i,
    input  logic [1:0]      dbg_size_i,
    input  logic [XLEN-1:0] dbg_addr_i,
    input  logic [XLEN-1:0] dbg_wdata_i,
    output logic            dbg_gnt_o,
    output logic            dbg_rvalid_o,
    output logic [XLEN-1:0] dbg_rdata_o,
    output logic            dbg_err_o,
    output logic            mem_req_o,
    output logic            mem_we_o,
    output logic [AW-1:0]   mem_addr_o,
    output logic [3:0]      mem_be_o,
    output logic [XLEN-1:0] mem_wdata_o,
    input  logic [XLEN-1:0] mem_rdata_i
);

    localparam logic [3:0] STREAK_MAX = 4'(MaxCpuStreak);

    logic [3:0]      streak_r;
    logic            cpu_gnt_s;
    logic            dbg_gnt_s;
    logic            any_gnt_s;
    mem_req_t        sel_s;
    logic            align_err_s;
    logic [3:0]      be_s;
    logic [XLEN-1:0] wdata_sh_s;
    logic            rsp_valid_q;
    logic            rsp_owner_q;
    logic [1:0]      off_q;
    logic            err_q;
    logic            rsp_live_s;
    logic [XLEN-1:0] rsp_data_s;
    logic            unused_s;

    // grant selection: CPU first, debug forced in once the CPU streak is full
    always_comb begin
        cpu_gnt_s = 1'b0;
        dbg_gnt_s = 1'b0;
        if (rst_i) begin
            cpu_gnt_s = 1'b0;
            dbg_gnt_s = 1'b0;
        end else if (cpu_req_i && dbg_req_i) begin
            if (streak_r == STREAK_MAX) begin
                dbg_gnt_s = 1'b1;
            end else begin
                cpu_gnt_s = 1'b1;
            end
        end else begin
            cpu_gnt_s = cpu_req_i;
            dbg_gnt_s = dbg_req_i;
        end
    end

    assign any_gnt_s = cpu_gnt_s | dbg_gnt_s;

    // route the winning request onto the shared memory path
    always_comb begin
        sel_s = '0;
        if (dbg_gnt_s) begin
            sel_s = '{req: dbg_req_i, we: dbg_we_i, size: dbg_size_i,
                      addr: dbg_addr_i, wdata: dbg_wdata_i};
        end else begin
            sel_s = '{req: cpu_req_i, we: cpu_we_i, size: cpu_size_i,
                      addr: cpu_addr_i, wdata: cpu_wdata_i};
        end
    end

    dmem_lane_align #(.XLEN(XLEN)) u_lane_align (
        .size_i  (sel_s.size),
        .off_i   (sel_s.addr[1:0]),
        .wdata_i (sel_s.wdata),
        .err_o   (align_err_s),
        .be_o    (be_s),
        .wdata_o (wdata_sh_s)
    );

    // illegal accesses are granted but never reach the memory
    assign mem_req_o   = any_gnt_s & ~align_err_s;
    assign mem_we_o    = mem_req_o & sel_s.we;
    assign mem_addr_o  = sel_s.addr[AW+1:2];
    assign mem_be_o    = be_s;
    assign mem_wdata_o = wdata_sh_s;

    assign cpu_gnt_o   = cpu_gnt_s;
    assign dbg_gnt_o   = dbg_gnt_s;
    assign cpu_stall_o = cpu_req_i & ~cpu_gnt_s;

    // count consecutive CPU wins while debug is kept waiting
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            streak_r <= 4'd0;
        end else if (dbg_gnt_s || !dbg_req_i) begin
            streak_r <= 4'd0;
        end else if (cpu_gnt_s && (streak_r != STREAK_MAX)) begin
            streak_r <= streak_r + 4'd1;
        end else begin
            streak_r <= streak_r;
        end
    end

    // remember owner, lane offset and error of the access answered next cycle
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rsp_valid_q <= 1'b0;
            rsp_owner_q <= 1'b0;
            off_q       <= 2'd0;
            err_q       <= 1'b0;
        end else begin
            rsp_valid_q <= any_gnt_s;
            rsp_owner_q <= dbg_gnt_s;
            off_q       <= sel_s.addr[1:0];
            err_q       <= align_err_s;
        end
    end

    // a response that lands in a reset cycle is dropped, not delivered
    assign rsp_live_s = rsp_valid_q & ~rst_i;
    assign rsp_data_s = err_q ? '0 : (mem_rdata_i >> {off_q, 3'b000});

    assign cpu_rvalid_o = rsp_live_s & ~rsp_owner_q;
    assign cpu_err_o    = cpu_rvalid_o & err_q;
    assign cpu_rdata_o  = cpu_rvalid_o ? rsp_data_s : '0;
    assign dbg_rvalid_o = rsp_live_s & rsp_owner_q;
    assign dbg_err_o    = dbg_rvalid_o & err_q;
    assign dbg_rdata_o  = dbg_rvalid_o ? rsp_data_s : '0;

    assign unused_s = ^{sel_s.req, sel_s.addr[XLEN-1:AW+2]};

endmodule
